// File: rtl/mdu_sched.sv
// mdu_sched -- multiply/divide scheduler sitting in E beside the ALU.
// Owns architectural HI/LO, runs mult/multu/div/divu as fixed-latency
// busy periods, and executes mthi/mtlo/mfhi/mflo.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   E_MDUStart     : E-stage instruction is mult/multu/div/divu
//   E_MDUSelect    : 000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 111 none
//   E_MFSelect     : 00 mfhi, 01 mflo, 10 none
//   E_A, E_B       : forwarded GPR[rs], GPR[rt]
//   D_MDU          : D-stage instruction is an MDU instruction
//   MDU_Out        : mfhi/mflo result (combinational from HI/LO)
//   Busy           : operation in flight
//   D_MDUStall     : stall request to the hazard unit
//   HI, LO         : architectural HI/LO
module mdu_sched #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        E_MDUStart,
    input  logic [2:0]  E_MDUSelect,
    input  logic [1:0]  E_MFSelect,
    input  logic [31:0] E_A,
    input  logic [31:0] E_B,
    input  logic        D_MDU,
    output logic [31:0] MDU_Out,
    output logic        Busy,
    output logic        D_MDUStall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [31:0]        hi_q, lo_q, hi_tmp_q, lo_tmp_q;
    logic               wr_q;      // commit enabled (cleared on divide by zero)
    logic               busy_q;

    // Result datapath, evaluated from the E operands in the launch cycle
    logic               is_div, is_uns, a_neg, b_neg, div_zero;
    logic [31:0]        a_mag, b_mag, divisor, q_mag, r_mag;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        res_hi, res_lo;

    always_comb begin
        is_div   = E_MDUSelect[1];
        is_uns   = E_MDUSelect[0];
        prod_s   = $signed({{32{E_A[31]}}, E_A}) * $signed({{32{E_B[31]}}, E_B});
        prod_u   = {32'b0, E_A} * {32'b0, E_B};
        // Sign/magnitude divide: 0x80000000 / -1 falls out naturally as
        // magnitude 0x80000000 with a positive sign, i.e. LO = 0x80000000.
        a_neg    = E_A[31] & ~is_uns;
        b_neg    = E_B[31] & ~is_uns;
        a_mag    = a_neg ? -E_A : E_A;
        b_mag    = b_neg ? -E_B : E_B;
        div_zero = is_div && (E_B == 32'd0);
        divisor  = div_zero ? 32'd1 : b_mag;   // keep the divider defined
        q_mag    = a_mag / divisor;
        r_mag    = a_mag % divisor;
        if (is_div) begin
            res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
            res_hi = a_neg ? -r_mag : r_mag;
        end else begin
            res_hi = is_uns ? prod_u[63:32] : prod_s[63:32];
            res_lo = is_uns ? prod_u[31:0]  : prod_s[31:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            hi_tmp_q <= '0;
            lo_tmp_q <= '0;
            wr_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (E_MDUStart) begin
                        hi_tmp_q <= res_hi;
                        lo_tmp_q <= res_lo;
                        wr_q     <= ~div_zero;
                        cnt_q    <= is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                        state_q  <= BUSY;
                        busy_q   <= 1'b1;
                    end else if (E_MDUSelect == 3'b100) begin
                        hi_q <= E_A;
                    end else if (E_MDUSelect == 3'b101) begin
                        lo_q <= E_A;
                    end
                end
                BUSY: begin
                    // Any start/mt arriving here is ignored by construction.
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        if (wr_q) begin
                            hi_q <= hi_tmp_q;
                            lo_q <= lo_tmp_q;
                        end
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        case (E_MFSelect)
            2'b00:   MDU_Out = hi_q;
            2'b01:   MDU_Out = lo_q;
            default: MDU_Out = 32'd0;
        endcase
    end

    assign Busy       = busy_q;
    assign D_MDUStall = D_MDU & (E_MDUStart | busy_q);
    assign HI         = hi_q;
    assign LO         = lo_q;

endmodule

// File: doc/mdu_sched.md
# mdu_sched

Multiply/divide scheduler for the five-stage pipelined CPU. It owns HI/LO, sequences multi-cycle `mult`/`multu`/`div`/`divu` operations launched from E, and executes `mthi`/`mtlo`/`mfhi`/`mflo`. It raises the D-stage stall that keeps any further MDU instruction out of E while an operation is pending. It sits in E beside the ALU and is driven by the decoded `MDUStart`, `MDUSelect` and `MFSelect` fields.

## Interface

**Parameters**
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range ≥ 1.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range ≥ 1.

**Ports**
- `clk` in 1: the single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `E_MDUStart` in 1: the E-stage instruction is `mult`, `multu`, `div` or `divu`.
- `E_MDUSelect` in 3: 000 `mult`, 001 `multu`, 010 `div`, 011 `divu`, 100 `mthi`, 101 `mtlo`, 111 none.
- `E_MFSelect` in 2: 00 `mfhi`, 01 `mflo`, 10 none.
- `E_A` in 32: forwarded GPR[rs].
- `E_B` in 32: forwarded GPR[rt].
- `D_MDU` in 1: the D-stage instruction is an MDU instruction (md, mf or mt).
- `MDU_Out` out 32: the `mfhi`/`mflo` result, selected into the E result mux.
- `Busy` out 1: an operation is in flight.
- `D_MDUStall` out 1: stall request to the hazard unit.
- `HI` out 32: architectural HI.
- `LO` out 32: architectural LO.

## Operation

**States**
- IDLE: `Busy` = 0.
- BUSY: counter `cnt` in 1..N.

**IDLE, `E_MDUStart` = 1**
- Compute the result from `E_A`/`E_B` and latch it into `hi_tmp`/`lo_tmp`.
- Load `cnt` with N: `MULT_CYCLES` for multiply, `DIV_CYCLES` for divide.
- Go to BUSY.

**Arithmetic**
- `mult`: signed 64-bit product; `multu`: unsigned. {HI, LO} = product.
- `div`: LO = quotient truncated toward zero; HI = remainder, sign follows the dividend.
- Signed divide 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0.
- `divu`: unsigned quotient and remainder.
- Divide by zero (`E_B` = 0): HI/LO are not updated. The unit still goes BUSY for `DIV_CYCLES`.

**BUSY**
- Decrement `cnt` each cycle.
- On the edge where `cnt` = 1: HI <= `hi_tmp`, LO <= `lo_tmp`, go to IDLE.

**`mthi` / `mtlo` in IDLE**
- HI (or LO) <= `E_A` at the end of that cycle. No busy period.

**Output selection (combinational)**
- `MDU_Out` = HI when `E_MFSelect` = 00, LO when 01, otherwise 0.
- `D_MDUStall` = `D_MDU` & (`E_MDUStart` | `Busy`).

**Illegal while BUSY**
- `E_MDUStart`, `mthi` or `mtlo` arriving in BUSY cannot occur when the stall is honoured. If it does occur, it is ignored: no state change, no restart.

**Reset**
- Any cycle, including mid-BUSY: next state IDLE, `cnt` = 0, HI = LO = 0.
- Pending `hi_tmp`/`lo_tmp` are discarded.

## Timing

**Reset values:** HI = 0, LO = 0, `Busy` = 0, `MDU_Out` = 0 with `E_MFSelect` = 10, `D_MDUStall` = 0 with `D_MDU` = 0.

**Operation launched in E at cycle t**
- `Busy` = 1 in cycles t+1 .. t+N.
- HI/LO hold their new values from cycle t+N+1.
- `Busy` = 0 in cycle t+N+1.

**Stall window**
- `D_MDUStall` is high in cycles t .. t+N when `D_MDU` = 1.
- An `mfhi` held in D therefore enters E at t+N+2 and reads the committed value.

**Move-to / move-from**
- `mthi`/`mtlo` in E at cycle t: a following `mfhi`/`mflo` in E at t+1 reads the new value.
- `MDU_Out` has zero latency from HI/LO.

**Back-to-back:** a new start is accepted in cycle t+N+1 (IDLE) at the earliest.

## Test plan

1. **Reset and idle:** assert `reset` for 2 cycles, then release → HI = LO = 0, `Busy` = 0, `D_MDUStall` = 0 with `D_MDU` = 1 and no start.
2. **Multiply:** `mult` with `E_A` = 0xFFFFFFFF, `E_B` = 2 → `Busy` high exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE. Repeat with `multu` → HI = 0x00000001, LO = 0xFFFFFFFE.
3. **Signed divide with stall:** `div` with `E_A` = 0xFFFFFFF9 (−7), `E_B` = 2, `D_MDU` = 1 held → `D_MDUStall` high cycles t..t+10, `Busy` high 10 cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. Also `div` 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
4. **Move-to then move-from:** `mthi` with `E_A` = 0x00001234, next cycle `mfhi` → `MDU_Out` = 0x00001234. `mtlo` 0xDEADBEEF, then `mflo` → 0xDEADBEEF. `Busy` never rises.
5. **Reset mid-operation:** start `divu` 100/7, assert `reset` in the 3rd `Busy` cycle → next cycle `Busy` = 0, HI = LO = 0, and no commit occurs 10 cycles later.
6. **Divide by zero and illegal start:** `divu` with `E_B` = 0 and HI/LO preloaded to 0x11111111/0x22222222 → `Busy` 10 cycles, HI/LO unchanged. During BUSY, drive `E_MDUStart` with `mult` 3*3 → ignored; `Busy` still drops after the original 10 cycles and HI/LO are unchanged.
